// File: rtl/arc4_pkg.sv
// Shared definitions for the RC4 keystream/decrypt engine: FSM states and
// the printable-ASCII test applied to recovered plaintext.
package arc4_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WT_LEN,
    WR_LEN,
    RD_SI,
    WT_SI,
    RD_SJ,
    WT_SJ,
    WR_I,
    WR_J,
    RD_PAD,
    WT_PAD,
    WR_PT
  } state_t;

  localparam logic [7:0] ASCII_LO = 8'h20;
  localparam logic [7:0] ASCII_HI = 8'h7E;

  function automatic logic printable(input logic [7:0] b);
    return (b >= ASCII_LO) && (b <= ASCII_HI);
  endfunction

endpackage

// File: rtl/prga.sv
// RC4 PRGA: walks the KSA-initialised S array, XORs the keystream with the
// length-prefixed ciphertext and writes length-prefixed plaintext.
module prga
  import arc4_pkg::*;
#(
  parameter bit CHECK_ASCII = 1'b1,
  parameter bit EARLY_ABORT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       pt_ok,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  state_t     state;
  logic [7:0] i, j, k, len;
  logic [7:0] si, sj, ctb;
  logic       bad;

  logic [7:0] i_nxt, j_nxt, pad_idx, pt_byte;
  logic       bad_now;

  // RAM data is consumed two cycles after its address, so every read
  // state is followed by a wait state that holds the same address.
  assign i_nxt   = i + 8'd1;
  assign j_nxt   = j + s_rddata;
  assign pad_idx = si + sj;
  assign pt_byte = s_rddata ^ ctb;
  assign bad_now = CHECK_ASCII && !printable(pt_byte);
  assign rdy     = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      len   <= '0;
      si    <= '0;
      sj    <= '0;
      ctb   <= '0;
      bad   <= 1'b0;
      pt_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: if (en) begin
          state <= RD_LEN;
          pt_ok <= 1'b0;
        end
        RD_LEN: state <= WT_LEN;
        WT_LEN: state <= WR_LEN;
        WR_LEN: begin
          len <= ct_rddata;
          i   <= '0;
          j   <= '0;
          k   <= 8'd1;
          bad <= 1'b0;
          if (ct_rddata == 8'd0) begin
            state <= IDLE;
            pt_ok <= 1'b1;
          end else begin
            state <= RD_SI;
          end
        end
        RD_SI: begin
          i     <= i_nxt;
          state <= WT_SI;
        end
        WT_SI: state <= RD_SJ;
        RD_SJ: begin
          si    <= s_rddata;
          ctb   <= ct_rddata;
          j     <= j_nxt;
          state <= WT_SJ;
        end
        WT_SJ: state <= WR_I;
        WR_I: begin
          sj    <= s_rddata;
          state <= WR_J;
        end
        WR_J:   state <= RD_PAD;
        RD_PAD: state <= WT_PAD;
        WT_PAD: state <= WR_PT;
        WR_PT: begin
          if (bad_now && EARLY_ABORT) begin
            state <= IDLE;
            pt_ok <= 1'b0;
          end else if (k == len) begin
            state <= IDLE;
            pt_ok <= !(bad || bad_now);
          end else begin
            k     <= k + 8'd1;
            bad   <= bad || bad_now;
            state <= RD_SI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Addresses and write strobes are decoded from state so that IDLE (and
  // therefore reset) drives every memory port to zero.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state)
      WR_LEN: begin
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
      end
      RD_SI: begin
        s_addr  = i_nxt;
        ct_addr = k;
      end
      WT_SI: begin
        s_addr  = i;
        ct_addr = k;
      end
      RD_SJ: begin
        s_addr  = j_nxt;
        ct_addr = k;
      end
      WT_SJ: s_addr = j;
      WR_I: begin
        s_addr   = i;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
      end
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
      end
      RD_PAD, WT_PAD: s_addr = pad_idx;
      WR_PT: begin
        pt_addr   = k;
        pt_wrdata = pt_byte;
        pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Bench for prga: two instances (ASCII check on / off) with behavioural
// synchronous RAMs, fixed vectors, random runs against an RC4 model.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en[2], rdy[2], pt_ok[2], s_wren[2], pt_wren[2];
  logic [7:0] s_addr[2], s_rddata[2], s_wrdata[2];
  logic [7:0] ct_addr[2], ct_rddata[2], pt_addr[2], pt_wrdata[2];

  always #5 clk = ~clk;

  prga #(.CHECK_ASCII(1'b1), .EARLY_ABORT(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .pt_ok(pt_ok[0]),
    .s_addr(s_addr[0]), .s_rddata(s_rddata[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rddata[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0])
  );

  prga #(.CHECK_ASCII(1'b0), .EARLY_ABORT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .pt_ok(pt_ok[1]),
    .s_addr(s_addr[1]), .s_rddata(s_rddata[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rddata[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1])
  );

  logic [7:0] s_init[256], ct_mem[256];
  logic [7:0] s_mem[2][256], pt_mem[2][256];
  logic       pt_wr[2][256];
  logic       load[2];
  int         s_wr_cnt[2], start_cnt[2];
  int         both_cnt = 0;

  // Memories, write tracking and run-start counting live in one process.
  always @(posedge clk) begin
    for (int x = 0; x < 2; x++) begin
      ct_rddata[x] <= ct_mem[ct_addr[x]];
      s_rddata[x]  <= s_mem[x][s_addr[x]];
      if (load[x]) begin
        for (int a = 0; a < 256; a++) begin
          s_mem[x][a] <= s_init[a];
          pt_wr[x][a] <= 1'b0;
        end
        s_wr_cnt[x]  <= 0;
        start_cnt[x] <= 0;
      end else begin
        if (s_wren[x]) begin
          s_mem[x][s_addr[x]] <= s_wrdata[x];
          s_wr_cnt[x] <= s_wr_cnt[x] + 1;
        end
        if (pt_wren[x]) begin
          pt_mem[x][pt_addr[x]] <= pt_wrdata[x];
          pt_wr[x][pt_addr[x]]  <= 1'b1;
        end
        if (rdy[x] && en[x] && rst_n) start_cnt[x] <= start_cnt[x] + 1;
      end
      if (s_wren[x] && pt_wren[x]) both_cnt <= both_cnt + 1;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference RC4 over the ciphertext table, starting from s_init.
  logic [7:0] m_s[256], m_pt[256];
  int         m_nw, m_cyc;
  bit         m_ok;

  task automatic model(input bit chk_a, input bit early);
    int s[256];
    int ii, jj, len, t, p;
    for (int a = 0; a < 256; a++) s[a] = int'(s_init[a]);
    len = int'(ct_mem[0]);
    m_pt[0] = ct_mem[0];
    m_ok = 1'b1;
    m_nw = len;
    ii = 0;
    jj = 0;
    for (int kk = 1; kk <= len; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      p = s[(s[ii] + s[jj]) % 256] ^ int'(ct_mem[kk]);
      m_pt[kk] = p[7:0];
      if (chk_a && (p < 32 || p > 126)) begin
        m_ok = 1'b0;
        if (early) begin
          m_nw = kk;
          break;
        end
      end
    end
    if (!chk_a) m_ok = 1'b1;
    m_cyc = 3 + 9 * m_nw;
    for (int a = 0; a < 256; a++) m_s[a] = s[a][7:0];
  endtask

  task automatic set_identity();
    for (int a = 0; a < 256; a++) s_init[a] = a[7:0];
  endtask

  task automatic set_random_perm();
    logic [7:0] t;
    int r;
    set_identity();
    for (int a = 255; a > 0; a--) begin
      r = int'($urandom_range(a, 0));
      t = s_init[a]; s_init[a] = s_init[r]; s_init[r] = t;
    end
  endtask

  // Keystream does not depend on ciphertext, so a chosen plaintext can be
  // turned into ciphertext through the model run on an all-zero message.
  task automatic prep_ct(input int len, input bit printable_pt);
    ct_mem[0] = len[7:0];
    for (int kk = 1; kk <= len; kk++) ct_mem[kk] = 8'h00;
    model(1'b0, 1'b0);
    for (int kk = 1; kk <= len; kk++)
      ct_mem[kk] = printable_pt ? (8'($urandom_range(126, 32)) ^ m_pt[kk]) : 8'($urandom);
  endtask

  task automatic do_load(input int x);
    @(negedge clk);
    load[x] = 1'b1;
    @(posedge clk);
    #1 load[x] = 1'b0;
  endtask

  task automatic run(input int x, output int cyc);
    @(negedge clk);
    en[x] = 1'b1;
    @(posedge clk);
    #1 en[x] = 1'b0;
    cyc = 0;
    while (!rdy[x] && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  function automatic int count_pt(input int x, input int lo);
    int c = 0;
    for (int a = lo; a < 256; a++) if (pt_wr[x][a]) c++;
    return c;
  endfunction

  task automatic full_run(input int x, input string name);
    int cyc, bad_pt, bad_s;
    do_load(x);
    model(x == 0, 1'b1);
    run(x, cyc);
    check({name, " cycles"}, cyc, m_cyc);
    check({name, " pt_ok"}, int'(pt_ok[x]), int'(m_ok));
    check({name, " s_writes"}, s_wr_cnt[x], 2 * m_nw);
    bad_pt = 0;
    for (int a = 0; a <= m_nw; a++)
      if (!pt_wr[x][a] || pt_mem[x][a] !== m_pt[a]) bad_pt++;
    check({name, " pt_bytes_bad"}, bad_pt, 0);
    check({name, " pt_extra_writes"}, count_pt(x, m_nw + 1), 0);
    bad_s = 0;
    for (int a = 0; a < 256; a++) if (s_mem[x][a] !== m_s[a]) bad_s++;
    check({name, " s_final_bad"}, bad_s, 0);
  endtask

  typedef struct {
    int               inst;
    logic [3:0][7:0]  ctb;
    int               exp_ok;
    int               exp_cyc;
    int               exp_pt1;
    int               exp_npt;
    int               exp_swr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int cyc;
    en[0] = 1'b0; en[1] = 1'b0;
    load[0] = 1'b0; load[1] = 1'b0;
    set_identity();
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;

    // Reset holds the block idle, even with en asserted.
    @(negedge clk);
    en[0] = 1'b1;
    @(posedge clk);
    #1;
    check("rst rdy", int'(rdy[0]), 1);
    check("rst pt_ok", int'(pt_ok[0]), 0);
    check("rst s_wren", int'(s_wren[0]), 0);
    check("rst pt_wren", int'(pt_wren[0]), 0);
    check("rst addrs", int'(s_addr[0]) + int'(ct_addr[0]) + int'(pt_addr[0]), 0);
    @(negedge clk);
    en[0] = 1'b0;
    rst_n = 1'b1;

    tbl[0] = '{0, {8'h00, 8'h00, 8'h41, 8'h01}, 1, 12, 8'h43, 2, 2};
    tbl[1] = '{0, {8'h00, 8'h00, 8'h00, 8'h00}, 1, 3,  0,     1, 0};
    tbl[2] = '{0, {8'h41, 8'h41, 8'h02, 8'h03}, 0, 12, 8'h00, 2, 2};
    tbl[3] = '{1, {8'h41, 8'h41, 8'h02, 8'h03}, 1, 30, 8'h00, 4, 6};
    for (int v = 0; v < 4; v++) begin
      int x;
      x = tbl[v].inst;
      set_identity();
      for (int b = 0; b < 4; b++) ct_mem[b] = tbl[v].ctb[b];
      do_load(x);
      run(x, cyc);
      check($sformatf("vec%0d cycles", v), cyc, tbl[v].exp_cyc);
      check($sformatf("vec%0d pt_ok", v), int'(pt_ok[x]), tbl[v].exp_ok);
      check($sformatf("vec%0d pt0", v), int'(pt_mem[x][0]), int'(tbl[v].ctb[0]));
      if (tbl[v].ctb[0] != 8'h00)
        check($sformatf("vec%0d pt1", v), int'(pt_mem[x][1]), tbl[v].exp_pt1);
      check($sformatf("vec%0d pt_count", v), count_pt(x, 0), tbl[v].exp_npt);
      check($sformatf("vec%0d s_writes", v), s_wr_cnt[x], tbl[v].exp_swr);
      check($sformatf("vec%0d s1", v), int'(s_mem[x][1]), 1);
    end

    for (int r = 0; r < 16; r++) begin
      set_random_perm();
      prep_ct(int'($urandom_range(24, 1)), r[0]);
      full_run(r % 2 == 1 ? 1 : 0, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the second byte of a 4-byte run, then a clean rerun.
    set_random_perm();
    prep_ct(4, 1'b1);
    model(1'b1, 1'b1);
    do_load(0);
    @(negedge clk);
    en[0] = 1'b1;
    @(posedge clk);
    #1 en[0] = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst rdy", int'(rdy[0]), 1);
    check("midrst s_wren", int'(s_wren[0]), 0);
    check("midrst pt_wren", int'(pt_wren[0]), 0);
    check("midrst pt_count", count_pt(0, 0), 2);
    check("midrst pt1", int'(pt_mem[0][1]), int'(m_pt[1]));
    @(negedge clk);
    rst_n = 1'b1;
    full_run(0, "after_rst");

    // en held high: one start per idle cycle, period 13 for L=1.
    set_identity();
    ct_mem[0] = 8'h01;
    ct_mem[1] = 8'h41;
    do_load(0);
    @(negedge clk);
    en[0] = 1'b1;
    repeat (39) @(posedge clk);
    #1;
    check("cont starts", start_cnt[0], 3);
    check("cont rdy", int'(rdy[0]), 1);
    en[0] = 1'b0;
    @(posedge clk);
    #1 check("cont no_restart", start_cnt[0], 3);

    check("wren exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 The block SHALL have parameter CHECK_ASCII, default 1: when 1, check every plaintext byte for printability and report the result on pt_ok.
REQ-002 The block SHALL have parameter EARLY_ABORT, default 1: when 1 (and CHECK_ASCII=1), stop at the first non-printable byte.
REQ-003 Port clk, input, 1 bit: sole clock, rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port en, input, 1 bit: start request, sampled only while rdy=1.
REQ-006 Port rdy, output, 1 bit: idle and able to accept en.
REQ-007 Port pt_ok, output, 1 bit: last run produced all-printable plaintext; valid while rdy=1.
REQ-008 Ports s_addr (output, 8 bits), s_rddata (input, 8 bits), s_wrdata (output, 8 bits) and s_wren (output, 1 bit): port to the S-array RAM already initialised by KSA.
REQ-009 Ports ct_addr (output, 8 bits) and ct_rddata (input, 8 bits): ciphertext RAM, read-only. Byte 0 is the length L; bytes 1..L are the message.
REQ-010 Ports pt_addr (output, 8 bits), pt_wrdata (output, 8 bits) and pt_wren (output, 1 bit): plaintext RAM, write-only.
REQ-011 All RAMs SHALL be synchronous read: an address presented in cycle n gives rddata that the block samples in cycle n+2, via one wait state.

Function
REQ-012 Handshake: en=1 with rdy=1 SHALL start a run; rdy SHALL fall on the next edge; en while rdy=0 SHALL be ignored.
REQ-013 The FSM states SHALL be IDLE, RD_LEN, WT_LEN, WR_LEN, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_I, WR_J, RD_PAD, WT_PAD and WR_PT.
REQ-014 Prelude, RD_LEN -> WT_LEN -> WR_LEN: ct_addr=0; latch L; write pt[0]=L; set i=0, j=0, k=1.
REQ-015 If L=0, the block SHALL go WR_LEN -> IDLE, perform no S accesses and set pt_ok=1.
REQ-016 Per byte k, exactly 9 cycles:
- RD_SI: i=i+1 mod 256; s_addr=i; ct_addr=k.
- RD_SJ: latch si and ctb; j=j+si mod 256; s_addr=j.
- WR_I: latch sj; write s[i]=sj.
- WR_J: write s[j]=si.
- RD_PAD: s_addr=(si+sj) mod 256.
- WR_PT: write pt[k]=s_rddata XOR ctb.
REQ-017 All index arithmetic SHALL be 8-bit and wrap modulo 256; i=j SHALL leave S unchanged.
REQ-018 A byte SHALL be printable if it lies in 0x20..0x7E inclusive.
- pt_ok is cleared on start and set to 1 on normal completion only if every byte was printable.
- With CHECK_ASCII=0, pt_ok=1 at completion.
REQ-019 EARLY_ABORT: on a non-printable byte, WR_PT SHALL still write that byte, then go to IDLE with pt_ok=0; later pt bytes are not written.
REQ-020 After WR_PT with k=L, the FSM SHALL go to IDLE; rdy=1 exactly 3+9L cycles after the start edge.
REQ-021 s_wren and pt_wren SHALL each be high only in their write states, and never both in the same cycle.

Reset
REQ-022 While rst_n=0, the block SHALL hold: state=IDLE, rdy=1, pt_ok=0, s_wren=0, pt_wren=0, all addresses and data=0, and i, j, k, L=0.
REQ-023 Reset mid-run SHALL abort immediately; memory contents already written SHALL be left as-is.
REQ-024 Reset SHALL win over a simultaneous en.

Structure
REQ-025 Package arc4_pkg SHALL hold the state enum, ASCII_LO=8'h20, ASCII_HI=8'h7E and a printable() function.
REQ-026 No sub-module SHALL be used; the block is a single FSM plus datapath registers.

Verification
REQ-027 Reset: assert rst_n=0 -> rdy=1, pt_ok=0, s_wren=0, pt_wren=0.
REQ-028 Identity S (s[x]=x), ct={01,41}, pulse en -> pt[0]=01, pt[1]=43, s[1]=01, pt_ok=1, rdy high 12 cycles after start.
REQ-029 ct={00}: pt[0]=00, rdy back after 3 cycles, s_wren never asserted, pt_ok=1.
REQ-030 Identity S, ct={03,02,41,41}, EARLY_ABORT=1 -> pt[1]=00, no writes to pt[2..3], pt_ok=0, rdy after 12 cycles; with CHECK_ASCII=0 all 3 bytes are written and pt_ok=1.
REQ-031 Pulse rst_n low during the second byte of a 4-byte run -> state=IDLE and rdy=1 asynchronously; a new run then completes correctly from a fresh S.
REQ-032 Drive en=1 continuously through a run -> exactly one run per rdy=1 cycle; en while busy has no effect.
